sev_seg_capture: RTL and testbench

- Monitor/receiver for the multiplexed seven-segment bus driven by the seven-segment controller.
- Samples the active-low anode and segment lines, tracks the scan, decodes each lit pattern back to a 4-bit hex value and holds one value per digit position.
- Sits on the board pins or a loopback bus. Used for self-check of display content and for closed-loop test of the display path.

---
 rtl/sev_seg_capture.sv | 115 +++++++++++
 tb/tb_sev_seg_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_capture.sv
// sev_seg_capture: receiver for a multiplexed active-low seven-segment bus; define SEV_SEG_TIMEOUT_EN for a stalled-display timeout
module sev_seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS = 8
`ifdef SEV_SEG_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    bad_pattern,
  output logic                    multi_an,
  output logic [7:0]              err_count
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
  state_t state_q;
  logic [6:0] s_seg_q, p_seg_q;
  logic [NUM_DIGITS-1:0] s_an_q, p_an_q, seen_q, low, sel, seen_d, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_d;
  logic an_chg, chg, eval, none, one, hit, blank, multi_d, bad_d, to_hit;
  logic [3:0] val;
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction
  // stability tracking and evaluation of a sample that has stayed put long enough
  always_comb begin
    an_chg = s_an_q != p_an_q;
    chg = an_chg || s_seg_q != p_seg_q;
    cnt_d = chg ? CW'(1) : (cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + CW'(1));
    eval = state_q == TRACK && !chg && cnt_d == CW'(STABLE_CYCLES);
    low = ~s_an_q;
    none = low == '0;
    one = !none && (low & (low - NUM_DIGITS'(1))) == '0;
    {hit, val} = decode(s_seg_q);
    blank = s_seg_q == 7'h7F;
    sel = eval && one && (hit || blank) ? low : '0;
    multi_d = eval && !none && !one;
    bad_d = eval && one && !hit && !blank;
    seen_d = (&seen_q ? '0 : seen_q) | sel;
    valid_d = hit ? digit_valid | sel : digit_valid & ~sel;
    digits_d = digits;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel[i] && hit) digits_d[4*i +: 4] = val;
  end
`ifdef SEV_SEG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q;
  assign to_hit = sel == '0 && idle_q == TW'(TIMEOUT_CYCLES - 1);
  // cycles since the last commit; expiry means the display has stalled
  always_ff @(posedge clk)
    idle_q <= reset || sel != '0 || to_hit ? '0 : idle_q + TW'(1);
`else
  assign to_hit = 1'b0;
`endif
  // input sampling, scan FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg_q <= '1;
      s_an_q <= '1;
      p_seg_q <= '1;
      p_an_q <= '1;
      cnt_q <= '0;
      state_q <= IDLE;
      digits <= '0;
      digit_valid <= '0;
      seen_q <= '0;
      frame_done <= 1'b0;
      bad_pattern <= 1'b0;
      multi_an <= 1'b0;
      err_count <= '0;
    end else begin
      s_seg_q <= seg;
      s_an_q <= an;
      p_seg_q <= s_seg_q;
      p_an_q <= s_an_q;
      cnt_q <= cnt_d;
      state_q <= to_hit ? IDLE :
                 state_q == IDLE ? (an_chg ? TRACK : IDLE) :
                 state_q == TRACK ? (eval ? LOCKED : TRACK) :
                 (chg ? TRACK : LOCKED);
      digits <= digits_d;
      digit_valid <= to_hit ? '0 : valid_d;
      seen_q <= to_hit ? '0 : seen_d;
      frame_done <= &seen_q;
      bad_pattern <= bad_d;
      multi_an <= multi_d;
      err_count <= (bad_d || multi_d) && err_count != 8'hFF ? err_count + 8'd1 : err_count;
    end
  end
endmodule

// File: tb/tb_sev_seg_capture.sv
// tb_sev_seg_capture: randomized self-checking bench for sev_seg_capture with a run-length reference model
module tb_sev_seg_capture;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic [7:0] an = 8'hFF;
  logic [31:0] digits;
  logic [7:0] digit_valid, err_count;
  logic frame_done, bad_pattern, multi_an;
  int errors = 0;
  int checks = 0;
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] exp_digits;
  logic [7:0] exp_valid, m_seen, m_prv_an, pend_an;
  logic [6:0] m_prv_seg, pend_seg;
  bit exp_frame, exp_bad, exp_multi, armed, pend;
  int exp_err, run;
  logic [50:0] act, exp;

  sev_seg_capture #(.STABLE_CYCLES(SC), .NUM_DIGITS(8)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .digits(digits),
    .digit_valid(digit_valid), .frame_done(frame_done), .bad_pattern(bad_pattern),
    .multi_an(multi_an), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // model state after the edge that sampled pins (a, s) with reset r
  task automatic model_edge(input logic [7:0] a, input logic [6:0] s, input bit r);
    logic [7:0] nseen;
    int lows, idx, v;
    if (r) begin
      exp_digits = '0; exp_valid = '0; m_seen = '0; exp_frame = 0; exp_bad = 0; exp_multi = 0;
      exp_err = 0; run = 0; armed = 0; pend = 0; m_prv_an = 8'hFF; m_prv_seg = 7'h7F;
      return;
    end
    exp_frame = &m_seen;
    nseen = exp_frame ? 8'h00 : m_seen;
    exp_bad = 0;
    exp_multi = 0;
    if (pend) begin
      lows = 0; idx = 0; v = -1;
      for (int i = 0; i < 8; i++) if (!pend_an[i]) begin lows++; idx = i; end
      for (int k = 0; k < 16; k++) if (tbl[k] == pend_seg) v = k;
      if (lows > 1) exp_multi = 1;
      else if (lows == 1) begin
        if (v >= 0) begin exp_digits[4*idx +: 4] = v[3:0]; exp_valid[idx] = 1; nseen[idx] = 1; end
        else if (pend_seg == 7'h7F) begin exp_valid[idx] = 0; nseen[idx] = 1; end
        else exp_bad = 1;
      end
      if ((exp_bad || exp_multi) && exp_err < 255) exp_err++;
    end
    m_seen = nseen;
    pend = 0;
    if (a != m_prv_an || s != m_prv_seg) begin
      run = 1;
      if (a != m_prv_an) armed = 1;
    end else if (run <= SC) run++;
    if (armed && run == SC) begin pend = 1; pend_an = a; pend_seg = s; end
    m_prv_an = a;
    m_prv_seg = s;
  endtask

  task automatic tick(input logic [7:0] a, input logic [6:0] s, input bit r);
    an = a; seg = s; reset = r;
    @(posedge clk);
    model_edge(a, s, r);
    #1;
    act = {digits, digit_valid, frame_done, bad_pattern, multi_an, err_count};
    exp = {exp_digits, exp_valid, exp_frame, exp_bad, exp_multi, exp_err[7:0]};
  endtask

  task automatic test_reset;
    tick(8'hFF, 7'h7F, 1);
    tick(8'hFF, 7'h7F, 1);
    checks++;
    if (act !== 51'h0) begin errors++; $display("FAIL reset: got %h want 0", act); end
  endtask

  task automatic test_single;
    for (int k = 1; k <= 10; k++) begin
      tick(8'hFE, 7'h40, 0);
      checks++;
      if (digit_valid !== (k >= 5 ? 8'h01 : 8'h00) || bad_pattern !== 1'b0 || multi_an !== 1'b0) begin
        errors++; $display("FAIL single_latency k=%0d: valid=%h bad=%b multi=%b", k, digit_valid, bad_pattern, multi_an);
      end
      checks++;
      if (act !== exp) begin errors++; $display("FAIL single_model k=%0d: got %h want %h", k, act, exp); end
    end
    checks++;
    if (digits[3:0] !== 4'h0 || err_count !== 8'h00) begin errors++; $display("FAIL single_value: digit0=%h err=%0d", digits[3:0], err_count); end
  endtask

  task automatic test_scan;
    logic [6:0] pat [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h0E};
    int frames = 0;
    for (int sc = 0; sc < 2; sc++)
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < 8; c++) begin
          tick(~(8'd1 << i), pat[i], 0);
          if (frame_done) frames++;
          checks++;
          if (act !== exp) begin errors++; $display("FAIL scan_model: got %h want %h", act, exp); end
        end
    checks++;
    if (digits !== 32'hF7654321 || digit_valid !== 8'hFF) begin errors++; $display("FAIL scan_value: digits=%h valid=%h", digits, digit_valid); end
    checks++;
    if (frames != 2) begin errors++; $display("FAIL scan_frames: got %0d want 2", frames); end
  endtask

  task automatic test_glitch;
    bit saw2 = 0;
    for (int c = 0; c < 9; c++) begin
      tick(8'hFE, c < 3 ? 7'h24 : 7'h30, 0);
      if (digits[3:0] === 4'h2) saw2 = 1;
      checks++;
      if (act !== exp) begin errors++; $display("FAIL glitch_model: got %h want %h", act, exp); end
    end
    checks++;
    if (saw2 || digits[3:0] !== 4'h3) begin errors++; $display("FAIL glitch_value: digit0=%h saw2=%0d want 3 and 0", digits[3:0], saw2); end
  endtask

  task automatic test_errors;
    int nm = 0, nb = 0;
    tick(8'hFF, 7'h7F, 1);
    for (int c = 0; c < 6; c++) begin
      tick(8'hFC, 7'h30, 0);
      if (multi_an) nm++;
      checks++;
      if (act !== exp) begin errors++; $display("FAIL multi_model: got %h want %h", act, exp); end
    end
    checks++;
    if (nm != 1 || err_count !== 8'd1 || digits !== 32'h0 || digit_valid !== 8'h0) begin
      errors++; $display("FAIL multi_an: pulses=%0d err=%0d digits=%h want 1 1 0", nm, err_count, digits);
    end
    for (int c = 0; c < 6; c++) begin
      tick(8'hFD, 7'h55, 0);
      if (bad_pattern) nb++;
      checks++;
      if (act !== exp) begin errors++; $display("FAIL bad_model: got %h want %h", act, exp); end
    end
    checks++;
    if (nb != 1 || err_count !== 8'd2) begin errors++; $display("FAIL bad_pattern: pulses=%0d err=%0d want 1 2", nb, err_count); end
  endtask

  task automatic test_saturate;
    for (int e = 0; e < 300; e++)
      for (int c = 0; c < 5; c++) tick(e[0] ? 8'hFD : 8'hFE, 7'h55, 0);
    checks++;
    if (err_count !== 8'd255 || exp_err != 255) begin errors++; $display("FAIL saturate: got %0d want 255", err_count); end
    tick(8'hFE, 7'h79, 0);
    tick(8'hFE, 7'h79, 0);
    tick(8'hFD, 7'h24, 1);
    checks++;
    if (act !== 51'h0) begin errors++; $display("FAIL mid_reset: got %h want 0", act); end
    for (int c = 0; c < 8; c++) begin
      tick(8'hFD, 7'h24, 0);
      checks++;
      if (act !== exp) begin errors++; $display("FAIL post_reset_model: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [6:0] s;
    int r, x, y;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      x = $urandom_range(0, 7);
      y = (x + $urandom_range(1, 7)) % 8;
      a = r < 8 ? ~(8'd1 << r) : r == 8 ? 8'hFF : ~((8'd1 << x) | (8'd1 << y));
      r = $urandom_range(0, 18);
      s = r < 16 ? tbl[r] : r == 16 ? 7'h7F : 7'($urandom);
      for (int c = $urandom_range(1, 8); c > 0; c--) begin
        tick(a, s, 0);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL random_model: an=%h seg=%h got %h want %h", a, s, act, exp); end
      end
    end
  endtask

  task automatic test_timeout;
    for (int c = 0; c < 6; c++) tick(8'hFE, 7'h79, 0);
    for (int c = 0; c < 60; c++) begin
      tick(8'hFF, 7'h7F, 0);
      checks++;
      if (act !== exp) begin errors++; $display("FAIL timeout_model: got %h want %h", act, exp); end
    end
    checks++;
    if (digit_valid[0] !== 1'b1 || digits[3:0] !== 4'h1) begin errors++; $display("FAIL no_timeout: valid=%h digit0=%h want bit0=1 1", digit_valid, digits[3:0]); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_scan;
    test_glitch;
    test_errors;
    test_saturate;
    test_random;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
